// File: rtl/output_quantize_stream.sv
// Rounds/shifts/saturates accumulator results to bytes, buffers them and emits each
// frame as one gap-free burst. Define RELU_QUANT_EN for ReLU + unsigned saturation.
module output_quantize_stream #(
    parameter int DEPTH   = 32,
    parameter int PREFILL = 16,
    parameter int ACC_W   = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    FrameStart,
    input  logic [15:0]             FrameBytes,
    input  logic [3:0]              ShiftAmt,
    input  logic                    AccValid,
    input  logic signed [ACC_W-1:0] AccIn,
    output logic                    AccReady,
    output logic                    StartOut,
    output logic [7:0]              ResultOut,
    output logic                    Busy,
    output logic                    FrameDone,
    output logic                    Underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] ZERO   = '0;
    localparam logic signed [ACC_W:0] U8_HI  = (ACC_W+1)'(255);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t              state, state_nx;
    logic [15:0]         len, acc_cnt, out_left;
    logic [3:0]          shift;
    logic [AW:0]         fifo_count;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [7:0]          mem [DEPTH];
    logic                v1, v2, zero_done;
    logic signed [ACC_W:0] r1, acc_ext, half, rnd_sum, rnd;
    logic [7:0]          q2, sat;
    logic [15:0]         len_in;
    logic                start_ok, accept, push, pop, empty;
    logic [1:0]          inflight;
    logic                unused_fb;

    assign unused_fb = ^FrameBytes[3:0];
    assign len_in    = {FrameBytes[15:4], 4'b0000};
    assign start_ok  = FrameStart & (state == IDLE);
    assign inflight  = {1'b0, v1} + {1'b0, v2};
    assign empty     = (fifo_count == '0);
    assign push      = v2;
    assign pop       = (state == STREAM) & ~empty;
    assign Busy      = (state != IDLE);
    assign AccReady  = Busy & (acc_cnt < len)
                       & ((32'(fifo_count) + 32'(inflight)) < 32'(DEPTH));
    assign accept    = AccValid & AccReady;
    assign StartOut  = (state == STREAM);
    assign ResultOut = pop ? mem[rd_ptr] : 8'h00;
    assign FrameDone = (state == DONE) | zero_done;

    // Round half up at ACC_W+1 bits so the bias add cannot overflow.
    always_comb begin
        acc_ext = {AccIn[ACC_W-1], AccIn};
        half    = (ACC_W+1)'(1) << (shift - 4'd1);
        rnd_sum = acc_ext + half;
        rnd     = (shift == 4'd0) ? acc_ext : (rnd_sum >>> shift);
    end

    always_comb begin
        sat = r1[7:0];
`ifdef RELU_QUANT_EN
        if (r1 < ZERO)
            sat = 8'h00;
        else if (r1 > U8_HI)
            sat = 8'hFF;
`else
        if (r1 < SAT_LO)
            sat = 8'h80;
        else if (r1 > SAT_HI)
            sat = 8'h7F;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start_ok && len_in != 16'd0) state_nx = FILL;
            FILL:   if (fifo_count >= (AW+1)'(PREFILL) || (acc_cnt == len && !v1 && !v2))
                        state_nx = STREAM;
            STREAM: if (out_left == 16'd1) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            shift      <= '0;
            acc_cnt    <= '0;
            out_left   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            r1         <= '0;
            q2         <= '0;
            zero_done  <= 1'b0;
            Underrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            zero_done <= start_ok && (len_in == 16'd0);
            if (start_ok) begin
                len      <= len_in;
                shift    <= ShiftAmt;
                acc_cnt  <= '0;
                out_left <= len_in;
                Underrun <= 1'b0;
            end else begin
                if (accept)
                    acc_cnt <= acc_cnt + 16'd1;
                if (state == STREAM) begin
                    out_left <= out_left - 16'd1;
                    if (empty)
                        Underrun <= 1'b1;
                end
            end
            v1 <= accept;
            if (accept)
                r1 <= rnd;
            v2 <= v1;
            if (v1)
                q2 <= sat;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            // Drop anything left over so a short/underrun frame cannot leak into the next.
            if (state == DONE) begin
                v1         <= 1'b0;
                v2         <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= q2;
    end

endmodule

// File: tb/tb_output_quantize_stream.sv
// Directed bench for output_quantize_stream: expected bytes are queued as inputs are
// accepted and compared as the burst comes out.
module tb_output_quantize_stream;

    logic               clock = 1'b0;
    logic               reset;
    logic               FrameStart;
    logic [15:0]        FrameBytes;
    logic [3:0]         ShiftAmt;
    logic               AccValid;
    logic signed [19:0] AccIn;
    logic               AccReady, StartOut, Busy, FrameDone, Underrun;
    logic [7:0]         ResultOut;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         burst_cycles = 0;
    int         bursts = 0;
    int         bursts_before = 0;
    int         done_count = 0;
    logic       prev_start = 1'b0;
    logic [7:0] exp_b;

    always #5 clock = ~clock;

    output_quantize_stream dut (
        .clock(clock), .reset(reset), .FrameStart(FrameStart), .FrameBytes(FrameBytes),
        .ShiftAmt(ShiftAmt), .AccValid(AccValid), .AccIn(AccIn), .AccReady(AccReady),
        .StartOut(StartOut), .ResultOut(ResultOut), .Busy(Busy), .FrameDone(FrameDone),
        .Underrun(Underrun)
    );

    function automatic logic [7:0] model_q(input int v, input int s);
        int  r;
        real d;
        if (s == 0) begin
            r = v;
        end else begin
            d = real'(v) + real'(1 << (s - 1));
            r = int'($floor(d / real'(1 << s)));
        end
`ifdef RELU_QUANT_EN
        if (r < 0) r = 0;
        if (r > 255) r = 255;
`else
        if (r < -128) r = -128;
        if (r > 127) r = 127;
`endif
        model_q = r[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output scoreboard: every StartOut cycle pops one expected byte.
    always @(negedge clock) begin
        if (StartOut === 1'b1) begin
            burst_cycles++;
            if (!prev_start) bursts++;
            vectors++;
            assert (exp_q.size() != 0)
            else begin
                miscompares++;
                $error("FAIL result_unexpected observed=%02h expected=none", ResultOut);
            end
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                vectors++;
                assert (ResultOut === exp_b)
                else begin
                    miscompares++;
                    $error("FAIL result_byte observed=%02h expected=%02h", ResultOut, exp_b);
                end
            end
        end
        if (FrameDone === 1'b1) done_count++;
        prev_start = (StartOut === 1'b1);
    end

    task automatic send(input int v, input logic [7:0] e);
        int guard = 0;
        @(negedge clock);
        AccValid = 1'b1;
        AccIn    = v[19:0];
        while (AccReady !== 1'b1 && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 500) begin
            check("acc_ready_timeout", 32'(AccReady), 32'd1);
        end else begin
            @(posedge clock);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        AccValid = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] fb, input logic [3:0] s);
        @(negedge clock);
        AccValid      = 1'b0;
        FrameStart    = 1'b1;
        FrameBytes    = fb;
        ShiftAmt      = s;
        burst_cycles  = 0;
        bursts_before = bursts;
        @(negedge clock);
        FrameStart = 1'b0;
    endtask

    task automatic wait_done(input int len);
        int guard = 0;
        #1;
        while (FrameDone !== 1'b1 && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("frame_done_seen", 32'(FrameDone), 32'd1);
        check("start_low_at_done", 32'(StartOut), 32'd0);
        check("start_before_done", 32'(prev_start), 32'(len != 0));
        check("burst_len", 32'(burst_cycles), 32'(len));
        check("burst_count", 32'(bursts - bursts_before), 32'(len != 0));
        @(posedge clock);
        #1;
        check("done_one_cycle", 32'(FrameDone), 32'd0);
        check("idle_after_done", 32'(Busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         vals_b[5];
        logic [7:0] tbl_b[5];
        int         v;
        int         g;
        int         done_before;

        vals_b = '{24, 23, -24, 5000, -5000};
`ifdef RELU_QUANT_EN
        tbl_b = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'h00};
`else
        tbl_b = '{8'h02, 8'h01, 8'hFF, 8'h7F, 8'h80};
`endif
        reset = 1'b1; FrameStart = 1'b0; FrameBytes = '0; ShiftAmt = '0;
        AccValid = 1'b0; AccIn = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_acc_ready", 32'(AccReady), 32'd0);
        check("rst_start_out", 32'(StartOut), 32'd0);
        check("rst_result_out", 32'(ResultOut), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_frame_done", 32'(FrameDone), 32'd0);
        check("rst_underrun", 32'(Underrun), 32'd0);
        reset = 1'b0;

        // 16 bytes, no shift
        start_frame(16'd16, 4'd0);
        check("a_busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 16; i++) send(i, 8'(i));
        idle_inputs();
        wait_done(16);

        // rounding/saturation at S=4
        start_frame(16'd16, 4'd4);
        for (int i = 0; i < 5; i++) send(vals_b[i], tbl_b[i]);
        for (int i = 0; i < 11; i++) begin
            v = i * 97 - 600;
            send(v, model_q(v, 4));
        end
        idle_inputs();
        wait_done(16);

        // 64 bytes with valid held high
        start_frame(16'd64, 4'd2);
        for (int i = 0; i < 64; i++) begin
            v = (i * 37) - 1100;
            send(v, model_q(v, 2));
        end
        idle_inputs();
        wait_done(64);
        check("c_no_underrun", 32'(Underrun), 32'd0);

        // input stops after 21 bytes: remainder of the burst is zero padding
        start_frame(16'd32, 4'd0);
        for (int i = 0; i < 21; i++) send(i + 1, 8'(i + 1));
        idle_inputs();
        for (int i = 0; i < 11; i++) exp_q.push_back(8'h00);
        wait_done(32);
        check("d_underrun_set", 32'(Underrun), 32'd1);

        // 0x0013 rounds down to 16; a FrameStart while busy is ignored
        start_frame(16'h0013, 4'd1);
        check("e_underrun_cleared", 32'(Underrun), 32'd0);
        for (int i = 0; i < 8; i++) begin
            v = i * 50 - 200;
            send(v, model_q(v, 1));
        end
        @(negedge clock);
        AccValid   = 1'b0;
        FrameStart = 1'b1;
        FrameBytes = 16'h0040;
        ShiftAmt   = 4'd0;
        @(negedge clock);
        FrameStart = 1'b0;
        check("e_busy_kept", 32'(Busy), 32'd1);
        for (int i = 8; i < 16; i++) begin
            v = i * 50 - 200;
            send(v, model_q(v, 1));
        end
        idle_inputs();
        wait_done(16);
        check("e_no_underrun", 32'(Underrun), 32'd0);

        // zero-length frame
        start_frame(16'h000F, 4'd0);
        check("z_not_busy", 32'(Busy), 32'd0);
        check("z_no_ready", 32'(AccReady), 32'd0);
        wait_done(0);

        // reset during byte 5 of the burst
        start_frame(16'd16, 4'd0);
        for (int i = 0; i < 16; i++) send(i * 3, 8'(i * 3));
        idle_inputs();
        #1;
        g = 0;
        while (!(StartOut === 1'b1 && burst_cycles == 4) && g < 500) begin
            @(posedge clock);
            #1;
            g++;
        end
        check("r_reached_byte5", 32'(StartOut), 32'd1);
        done_before = done_count;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("r_start_low", 32'(StartOut), 32'd0);
        check("r_busy_low", 32'(Busy), 32'd0);
        check("r_ready_low", 32'(AccReady), 32'd0);
        check("r_result_zero", 32'(ResultOut), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        check("r_no_frame_done", 32'(done_count), 32'(done_before));
        exp_q.delete();

        // frame after reset must not see stale FIFO contents
        start_frame(16'd16, 4'd3);
        for (int i = 0; i < 16; i++) begin
            v = 1200 - i * 151;
            send(v, model_q(v, 3));
        end
        idle_inputs();
        wait_done(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
